aidc_lite_concat_arbiter: RTL and testbench
===========================================

# aidc_lite_concat_arbiter

Packet-level round-robin arbiter that shares one AIDC-Lite code-concatenation datapath among `NUM_REQ` compressor lanes. It grants a whole packet (sop..eop) to one lane and forwards its beats to the concatenator. After eop it holds off the next packet until the concatenator reports done. It exposes the current owner so the concatenator's 64-bit word writes can be steered, and it returns a per-packet completion with the fail flag.

## Interface
- `NUM_REQ`, 4: number of requesting lanes (2..8).
- `DATA_SIZE`, 66: code width per beat.
- `ID_W`, $clog2(NUM_REQ): lane index width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  NUM_REQ  per-lane beat valid.
- `req_sop_i`  in  NUM_REQ  per-lane first-beat marker.
- `req_eop_i`  in  NUM_REQ  per-lane last-beat marker.
- `req_data_i`  in  NUM_REQ*DATA_SIZE  per-lane code bits; lane i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- `req_size_i`  in  NUM_REQ*7  per-lane code length in bits; lane i occupies bits [i*7 +: 7].
- `req_ready_o`  out  NUM_REQ  beat accepted this cycle (combinational).
- `cc_valid_o`, `cc_sop_o`, `cc_eop_o`  out  1 each  to concatenator.
- `cc_data_o`  out  DATA_SIZE  to concatenator.
- `cc_size_o`  out  7  to concatenator.
- `cc_done_i`  in  1  concatenator done (registered there; 1 after its reset).
- `cc_fail_i`  in  1  concatenator fail, valid when done.
- `owner_o`  out  ID_W  lane currently owning the datapath.
- `owner_valid_o`  out  1  owner_o meaningful.
- `cpl_valid_o`  out  1  one-cycle packet completion pulse.
- `cpl_id_o`  out  ID_W  completed lane.
- `cpl_fail_o`  out  1  captured cc_fail_i.

## Operation
- FSM states: IDLE, BUSY, DRAIN.
- **IDLE**
  - Candidates are lanes with `req_valid_i & req_sop_i`.
  - Pick the first candidate at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - On a pick, register `owner`, set `first=1`, go to BUSY, set `rr_ptr = owner+1` (wraps).
  - Lanes asserting valid without sop are ignored; their ready stays 0.
  - `req_ready_o` is all zero in IDLE.
- **BUSY**
  - `req_ready_o[owner] = 1`; all other lanes 0.
  - `cc_valid_o = req_valid_i[owner]`.
  - `cc_data_o` and `cc_size_o` are muxed from the owner lane.
  - `cc_sop_o = cc_valid_o & first`; lane sop bits are ignored after the grant.
  - `first` clears on the first forwarded beat.
  - `cc_eop_o = cc_valid_o & req_eop_i[owner]`.
  - Idle cycles inside a packet are allowed and forwarded as valid=0.
  - A forwarded eop beat moves the FSM to DRAIN.
- **DRAIN**
  - All outputs toward lanes and the concatenator are 0.
  - When `cc_done_i=1`: register `cpl_valid_o=1`, `cpl_id_o=owner`, `cpl_fail_o=cc_fail_i`, and go to IDLE.
- `owner_valid_o = (state != IDLE)`. `owner_o` is held through DRAIN so the final flush word is steered correctly.
- cc_* outputs are zero whenever not in BUSY.

## Timing
- **Reset** (async, takes effect immediately):
  - state=IDLE, `rr_ptr=0`, `owner=0`, `first=0`.
  - `cpl_valid_o=0`, `cpl_id_o=0`, `cpl_fail_o=0`.
  - All combinational outputs evaluate to 0.
- Reset mid-packet abandons the packet; no completion is issued. The concatenator is reset by the same `rst_n`.
- **Grant latency:** sop visible in IDLE at cycle t → BUSY and `req_ready_o[owner]=1` at t+1. The lane must hold its sop beat until ready.
- **Beat transfer:** occurs in any BUSY cycle with `req_valid_i[owner]=1`. Zero added latency (combinational pass-through).
- **Drain:** eop forwarded at cycle k → DRAIN at k+1.
  - `cc_done_i` is sampled from k+1 on. It is already 1 at k+1 when the concatenator closed the block in the eop cycle.
  - It is 0 at k+1 and 1 at k+2 when a residual flush word is pending.
- **Completion:** `cpl_valid_o` is high exactly one cycle, the cycle after done is seen in DRAIN. The FSM is in IDLE that same cycle and may grant that cycle.
- **Throughput:** minimum 1-beat packet occupies 3 cycles (grant, beat, drain).
- **Single-beat packets:** sop+eop on the same beat is legal.
- **Fairness:** with all lanes requesting continuously, grants cycle 0,1,…,NUM_REQ-1,0. A lane with a new sop competes on the completion cycle like any other.

## Test plan
- **Single-beat packet:** lane 2 valid+sop+eop, size 6 at cycle 0. Required: ready[2] and cc_valid/sop/eop at cycle 1; done=1 at cycle 2; cpl_valid at 3 with id=2, fail=0; owner_valid high cycles 1-2.
- **Round-robin:** lanes 0 and 3 request simultaneously with 2-beat packets. Required: grant order 0 then 3. A third packet from lane 0 waiting against lane 1 is granted to lane 1 first (rr_ptr=1 after lane 0; it moves to 0 after lane 3's grant, so lane 0 wins the next round).
- **Pending flush:** 3-beat packet, cc_done_i held 0 for two DRAIN cycles then 1, with cc_fail_i=1. Required: no cc_valid during DRAIN; owner_o stable; cpl_valid 1 cycle after done with fail=1.
- **Mid-packet gap and ignored stray beat:** owner drops valid for 2 cycles mid-packet; no cc_valid in the gap. Separately, lane 1 asserts valid without sop in IDLE: it is never granted and ready[1] stays 0.
- **Async reset mid-BUSY:** assert rst_n low between edges. Required: state IDLE and all outputs 0 immediately; no cpl pulse; after release, lane 0 is granted first.
- **Saturation:** all 4 lanes stream back-to-back 1-beat packets for 16 grants. Required: each lane granted exactly 4 times in 0-1-2-3 order; one cpl per packet.

Source files
------------

// File: rtl/aidc_lite_concat_arbiter.sv
// Packet-level round-robin arbiter sharing one AIDC-Lite concatenator
// among several compressor lanes; tracks owner and reports completion.
module aidc_lite_concat_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 66,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ-1:0]           req_sop_i,
    input  logic [NUM_REQ-1:0]           req_eop_i,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data_i,
    input  logic [NUM_REQ*7-1:0]         req_size_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         cc_valid_o,
    output logic                         cc_sop_o,
    output logic                         cc_eop_o,
    output logic [DATA_SIZE-1:0]         cc_data_o,
    output logic [6:0]                   cc_size_o,
    input  logic                         cc_done_i,
    input  logic                         cc_fail_i,
    output logic [ID_W-1:0]              owner_o,
    output logic                         owner_valid_o,
    output logic                         cpl_valid_o,
    output logic [ID_W-1:0]              cpl_id_o,
    output logic                         cpl_fail_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [ID_W-1:0]     owner;
    logic [ID_W-1:0]     owner_n;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     rr_n;
    logic                first;
    logic                first_n;
    logic                cpl_valid_n;
    logic [ID_W-1:0]     cpl_id_n;
    logic                cpl_fail_n;
    logic [NUM_REQ-1:0]  cand;
    logic [ID_W-1:0]     pick;
    logic [ID_W-1:0]     idx;
    logic                found;

    function automatic logic [ID_W-1:0] wrap(input int v);
        return ID_W'(v % NUM_REQ);
    endfunction

    assign cand = req_valid_i & req_sop_i;

    // First sop-candidate at or after rr_ptr, wrapping around the lanes
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = wrap(int'(rr_ptr) + k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_n        = rr_ptr;
        first_n     = first;
        cpl_valid_n = 1'b0;
        cpl_id_n    = cpl_id_o;
        cpl_fail_n  = cpl_fail_o;
        req_ready_o = '0;
        cc_valid_o  = 1'b0;
        cc_sop_o    = 1'b0;
        cc_eop_o    = 1'b0;
        cc_data_o   = '0;
        cc_size_o   = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    owner_n = pick;
                    first_n = 1'b1;
                    rr_n    = wrap(int'(pick) + 1);
                end
            end
            BUSY: begin
                req_ready_o[owner] = 1'b1;
                cc_valid_o = req_valid_i[owner];
                cc_data_o  = req_data_i[int'(owner)*DATA_SIZE +: DATA_SIZE];
                cc_size_o  = req_size_i[int'(owner)*7 +: 7];
                cc_sop_o   = cc_valid_o & first;
                cc_eop_o   = cc_valid_o & req_eop_i[owner];
                if (cc_valid_o) begin
                    first_n = 1'b0;
                end
                if (cc_eop_o) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (cc_done_i) begin
                    cpl_valid_n = 1'b1;
                    cpl_id_n    = owner;
                    cpl_fail_n  = cc_fail_i;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            first       <= 1'b0;
            cpl_valid_o <= 1'b0;
            cpl_id_o    <= '0;
            cpl_fail_o  <= 1'b0;
        end else begin
            state       <= state_n;
            owner       <= owner_n;
            rr_ptr      <= rr_n;
            first       <= first_n;
            cpl_valid_o <= cpl_valid_n;
            cpl_id_o    <= cpl_id_n;
            cpl_fail_o  <= cpl_fail_n;
        end
    end

    // Owner stays visible through DRAIN to steer the final flush word
    assign owner_o       = owner;
    assign owner_valid_o = (state != IDLE);

endmodule

// File: tb/tb_aidc_lite_concat_arbiter.sv
// Directed bench for aidc_lite_concat_arbiter: grant timing, round-robin,
// drain/flush, gaps, stray beats, async reset and saturation.
module tb_aidc_lite_concat_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_sop;
    logic [3:0]   req_eop;
    logic [263:0] req_data;
    logic [27:0]  req_size;
    logic [3:0]   req_ready;
    logic         cc_valid;
    logic         cc_sop;
    logic         cc_eop;
    logic [65:0]  cc_data;
    logic [6:0]   cc_size;
    logic         cc_done;
    logic         cc_fail;
    logic [1:0]   owner;
    logic         owner_valid;
    logic         cpl_valid;
    logic [1:0]   cpl_id;
    logic         cpl_fail;

    aidc_lite_concat_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_sop_i     (req_sop),
        .req_eop_i     (req_eop),
        .req_data_i    (req_data),
        .req_size_i    (req_size),
        .req_ready_o   (req_ready),
        .cc_valid_o    (cc_valid),
        .cc_sop_o      (cc_sop),
        .cc_eop_o      (cc_eop),
        .cc_data_o     (cc_data),
        .cc_size_o     (cc_size),
        .cc_done_i     (cc_done),
        .cc_fail_i     (cc_fail),
        .owner_o       (owner),
        .owner_valid_o (owner_valid),
        .cpl_valid_o   (cpl_valid),
        .cpl_id_o      (cpl_id),
        .cpl_fail_o    (cpl_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pend [4];
    int blen [4];
    int beat [4];
    int gap  [4];
    bit stray[4];
    bit acc  [4];
    int grants[$];
    int cpls[$];
    int beats;
    int data_err;
    bit ov_q;
    int tests;
    int fails;

    function automatic logic [65:0] ldata(input int l, input int b);
        return {2'b10, 32'hC0DE_0000, 32'(l * 256 + b)};
    endfunction

    function automatic logic [6:0] lsize(input int l, input int b);
        return 7'(l * 2 + 2 + b);
    endfunction

    task automatic drive_lanes();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = stray[i] || (pend[i] > 0 && gap[i] == 0);
            req_sop[i]   = !stray[i] && pend[i] > 0 && gap[i] == 0
                           && beat[i] == 0;
            req_eop[i]   = !stray[i] && pend[i] > 0 && gap[i] == 0
                           && beat[i] == blen[i] - 1;
            req_data[i*66 +: 66] = ldata(i, beat[i]);
            req_size[i*7 +: 7]   = lsize(i, beat[i]);
        end
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < 4; i++) begin
            pend[i]  = 0;
            blen[i]  = 1;
            beat[i]  = 0;
            gap[i]   = 0;
            stray[i] = 0;
        end
    endtask

    task automatic clear_log();
        grants.delete();
        cpls.delete();
        beats    = 0;
        data_err = 0;
        ov_q     = 0;
    endtask

    // Observe at negedge, then advance lane models after the next posedge
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            acc[i] = req_valid[i] && req_ready[i];
        end
        if (owner_valid && !ov_q) grants.push_back(int'(owner));
        ov_q = owner_valid;
        if (cpl_valid) cpls.push_back(int'(cpl_id));
        if (req_ready !== 4'b0 &&
            (!owner_valid || req_ready !== (4'b1 << owner))) begin
            data_err++;
        end
        if (cc_valid) begin
            beats++;
            if (cc_data !== ldata(int'(owner), beat[owner]) ||
                cc_size !== lsize(int'(owner), beat[owner]) ||
                cc_sop !== (beat[owner] == 0) ||
                cc_eop !== (beat[owner] == blen[owner] - 1)) begin
                data_err++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                if (beat[i] == blen[i] - 1) begin
                    beat[i] = 0;
                    pend[i]--;
                end else begin
                    beat[i]++;
                end
            end
        end
        drive_lanes();
        for (int i = 0; i < 4; i++) begin
            if (gap[i] > 0) gap[i]--;
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (req_ready !== 4'b0 || cc_valid !== 1'b0 || owner_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_comb got ready=%b ccv=%b ov=%b want 0", req_ready, cc_valid, owner_valid);
        end
        tests++;
        if (cpl_valid !== 1'b0 || cpl_id !== 2'd0 || cpl_fail !== 1'b0 || owner !== 2'd0) begin
            fails++;
            $display("FAIL rst_regs got cplv=%b id=%0d f=%b own=%0d want 0", cpl_valid, cpl_id, cpl_fail, owner);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_round_robin();
        int exp_rr[4] = '{0, 1, 3, 0};
        clear_log();
        blen[0] = 2;
        blen[1] = 2;
        blen[3] = 2;
        pend[0] = 2;
        pend[3] = 1;
        drive_lanes();
        #1;
        tick();
        pend[1] = 1;
        drive_lanes();
        for (int c = 0; c < 60 && cpls.size() < 4; c++) tick();
        tests++;
        if (grants.size() != 4 || cpls.size() != 4) begin
            fails++;
            $display("FAIL rr_count got grants=%0d cpls=%0d want 4", grants.size(), cpls.size());
        end
        for (int j = 0; j < 4; j++) begin
            if (j < grants.size() && j < cpls.size()) begin
                tests++;
                if (grants[j] != exp_rr[j] || cpls[j] != exp_rr[j]) begin
                    fails++;
                    $display("FAIL rr_order[%0d] got grant=%0d cpl=%0d want %0d", j, grants[j], cpls[j], exp_rr[j]);
                end
            end
        end
        tests++;
        if (beats != 8 || data_err != 0) begin
            fails++;
            $display("FAIL rr_beats got beats=%0d err=%0d want 8/0", beats, data_err);
        end
    endtask

    task automatic test_single_beat();
        clear_log();
        blen[2] = 1;
        pend[2] = 1;
        drive_lanes();
        #1;
        tests++;
        if (req_ready !== 4'b0 || owner_valid !== 1'b0 || cc_valid !== 1'b0) begin
            fails++;
            $display("FAIL sb_c0 got ready=%b ov=%b ccv=%b want 0", req_ready, owner_valid, cc_valid);
        end
        tick();
        tests++;
        if (req_ready !== 4'b0100 || {cc_valid, cc_sop, cc_eop} !== 3'b111) begin
            fails++;
            $display("FAIL sb_c1 got ready=%b vse=%b want 0100/111", req_ready, {cc_valid, cc_sop, cc_eop});
        end
        tests++;
        if (cc_size !== 7'd6 || cc_data !== ldata(2, 0) || owner !== 2'd2 || owner_valid !== 1'b1) begin
            fails++;
            $display("FAIL sb_c1_data got size=%0d own=%0d ov=%b want 6/2/1", cc_size, owner, owner_valid);
        end
        tick();
        tests++;
        if (cc_valid !== 1'b0 || req_ready !== 4'b0 || owner_valid !== 1'b1 || owner !== 2'd2 || cpl_valid !== 1'b0) begin
            fails++;
            $display("FAIL sb_c2 got ccv=%b ready=%b ov=%b own=%0d cplv=%b want 0/0/1/2/0", cc_valid, req_ready, owner_valid, owner, cpl_valid);
        end
        tick();
        tests++;
        if (cpl_valid !== 1'b1 || cpl_id !== 2'd2 || cpl_fail !== 1'b0 || owner_valid !== 1'b0) begin
            fails++;
            $display("FAIL sb_c3 got cplv=%b id=%0d f=%b ov=%b want 1/2/0/0", cpl_valid, cpl_id, cpl_fail, owner_valid);
        end
        tick();
        tests++;
        if (cpl_valid !== 1'b0) begin
            fails++;
            $display("FAIL sb_c4_pulse got cplv=%b want 0", cpl_valid);
        end
    endtask

    task automatic test_flush();
        clear_log();
        cc_done = 1'b0;
        cc_fail = 1'b1;
        blen[1] = 3;
        pend[1] = 1;
        drive_lanes();
        #1;
        tick();
        tests++;
        if (req_ready !== 4'b0010 || cc_valid !== 1'b1 || cc_sop !== 1'b1) begin
            fails++;
            $display("FAIL fl_c1 got ready=%b ccv=%b sop=%b want 0010/1/1", req_ready, cc_valid, cc_sop);
        end
        tick();
        tests++;
        if (cc_valid !== 1'b1 || cc_sop !== 1'b0 || cc_eop !== 1'b0) begin
            fails++;
            $display("FAIL fl_c2 got v=%b s=%b e=%b want 1/0/0", cc_valid, cc_sop, cc_eop);
        end
        tick();
        tests++;
        if (cc_eop !== 1'b1) begin
            fails++;
            $display("FAIL fl_c3_eop got %b want 1", cc_eop);
        end
        for (int c = 4; c <= 6; c++) begin
            tick();
            tests++;
            if (cc_valid !== 1'b0 || req_ready !== 4'b0 || owner !== 2'd1 || owner_valid !== 1'b1 || cpl_valid !== 1'b0) begin
                fails++;
                $display("FAIL fl_drain_c%0d got ccv=%b ready=%b own=%0d ov=%b cplv=%b want 0/0/1/1/0", c, cc_valid, req_ready, owner, owner_valid, cpl_valid);
            end
        end
        cc_done = 1'b1;
        tick();
        tests++;
        if (cpl_valid !== 1'b1 || cpl_id !== 2'd1 || cpl_fail !== 1'b1 || owner_valid !== 1'b0) begin
            fails++;
            $display("FAIL fl_cpl got v=%b id=%0d f=%b ov=%b want 1/1/1/0", cpl_valid, cpl_id, cpl_fail, owner_valid);
        end
        cc_fail = 1'b0;
        tick();
        tests++;
        if (cpl_valid !== 1'b0 || data_err != 0) begin
            fails++;
            $display("FAIL fl_after got cplv=%b err=%0d want 0/0", cpl_valid, data_err);
        end
    endtask

    task automatic test_gap_stray();
        int bad;
        clear_log();
        blen[3] = 3;
        pend[3] = 1;
        drive_lanes();
        #1;
        tick();
        tests++;
        if (cc_valid !== 1'b1 || cc_sop !== 1'b1 || owner !== 2'd3) begin
            fails++;
            $display("FAIL gp_c1 got v=%b s=%b own=%0d want 1/1/3", cc_valid, cc_sop, owner);
        end
        gap[3] = 2;
        for (int c = 2; c <= 3; c++) begin
            tick();
            tests++;
            if (cc_valid !== 1'b0 || req_ready !== 4'b1000 || owner_valid !== 1'b1) begin
                fails++;
                $display("FAIL gp_gap_c%0d got ccv=%b ready=%b ov=%b want 0/1000/1", c, cc_valid, req_ready, owner_valid);
            end
        end
        tick();
        tests++;
        if (cc_valid !== 1'b1 || cc_sop !== 1'b0 || cc_data !== ldata(3, 1)) begin
            fails++;
            $display("FAIL gp_resume got v=%b s=%b data=%h want 1/0/%h", cc_valid, cc_sop, cc_data, ldata(3, 1));
        end
        tick();
        tick();
        tick();
        tests++;
        if (cpl_valid !== 1'b1 || cpl_id !== 2'd3 || beats != 3 || data_err != 0) begin
            fails++;
            $display("FAIL gp_cpl got v=%b id=%0d beats=%0d err=%0d want 1/3/3/0", cpl_valid, cpl_id, beats, data_err);
        end
        stray[1] = 1'b1;
        drive_lanes();
        #1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (req_ready !== 4'b0 || owner_valid !== 1'b0) bad++;
            tick();
        end
        tests++;
        if (bad != 0 || grants.size() != 1) begin
            fails++;
            $display("FAIL stray got bad_cycles=%0d grants=%0d want 0/1", bad, grants.size());
        end
        stray[1] = 1'b0;
        drive_lanes();
        #1;
    endtask

    task automatic test_async_reset();
        clear_log();
        blen[2] = 4;
        pend[2] = 1;
        drive_lanes();
        #1;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (owner_valid !== 1'b0 || req_ready !== 4'b0 || cc_valid !== 1'b0 || cc_data !== 66'd0 || cc_size !== 7'd0) begin
            fails++;
            $display("FAIL ar_now got ov=%b ready=%b ccv=%b size=%0d want 0", owner_valid, req_ready, cc_valid, cc_size);
        end
        tests++;
        if (owner !== 2'd0 || cpl_valid !== 1'b0) begin
            fails++;
            $display("FAIL ar_regs got own=%0d cplv=%b want 0/0", owner, cpl_valid);
        end
        clear_lanes();
        drive_lanes();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        tests++;
        if (cpl_valid !== 1'b0 || owner_valid !== 1'b0) begin
            fails++;
            $display("FAIL ar_release got cplv=%b ov=%b want 0/0", cpl_valid, owner_valid);
        end
        clear_log();
        pend[0] = 1;
        pend[3] = 1;
        drive_lanes();
        #1;
        for (int c = 0; c < 20 && cpls.size() < 2; c++) tick();
        tests++;
        if (grants.size() != 2 || cpls.size() != 2) begin
            fails++;
            $display("FAIL ar_count got grants=%0d cpls=%0d want 2", grants.size(), cpls.size());
        end else if (grants[0] != 0 || grants[1] != 3) begin
            fails++;
            $display("FAIL ar_order got %0d,%0d want 0,3", grants[0], grants[1]);
        end
    endtask

    task automatic test_saturation();
        int cnt[4];
        clear_log();
        for (int i = 0; i < 4; i++) begin
            blen[i] = 1;
            pend[i] = 4;
            cnt[i]  = 0;
        end
        drive_lanes();
        #1;
        for (int c = 0; c < 120 && cpls.size() < 16; c++) tick();
        tests++;
        if (grants.size() != 16 || cpls.size() != 16 || beats != 16 || data_err != 0) begin
            fails++;
            $display("FAIL sat_count got grants=%0d cpls=%0d beats=%0d err=%0d want 16/16/16/0", grants.size(), cpls.size(), beats, data_err);
        end
        for (int j = 0; j < 16; j++) begin
            if (j < grants.size()) begin
                cnt[grants[j]]++;
                tests++;
                if (grants[j] != j % 4) begin
                    fails++;
                    $display("FAIL sat_order[%0d] got %0d want %0d", j, grants[j], j % 4);
                end
            end
        end
        tests++;
        if (cnt[0] != 4 || cnt[1] != 4 || cnt[2] != 4 || cnt[3] != 4) begin
            fails++;
            $display("FAIL sat_fair got %0d/%0d/%0d/%0d want 4 each", cnt[0], cnt[1], cnt[2], cnt[3]);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        cc_done = 1'b1;
        cc_fail = 1'b0;
        clear_lanes();
        clear_log();
        drive_lanes();
        test_reset();
        test_round_robin();
        test_single_beat();
        test_flush();
        test_gap_stray();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
